word_byte_loader: RTL
=====================

Name: word_byte_loader

Overview:
- Transmit side of the byte-wide register-load interface: takes a 16-bit word over a valid/ready handshake and replays it as two byte writes (I, LH, enable, FunSel=01) into a half-loadable 16-bit register.
- Sits between the memory/fetch path and the instruction/address register.
- Drives the target's I/LH/enable/FunSel pins directly.
- Also issues register-clear commands (FunSel=00) on request.

Parameters:
- LOW_FIRST, 1: 1 = send low byte (LH=0) first, then high byte (LH=1); 0 = reverse.
- CNT_W, 8: width of the completed-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  word available
- in_ready  output  1  block can accept word this cycle
- in_word  input  16  word to transfer
- clear_req  input  1  request one clear command to target
- stall  input  1  target must not be written this cycle
- out_byte  output  8  byte to target I
- out_lh  output  1  half select to target LH (0 = bits[7:0], 1 = bits[15:8])
- out_funsel  output  2  target FunSel: 01 load, 00 clear
- out_enable  output  1  target enable
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after last byte of a word written
- word_count  output  CNT_W  number of completed words

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; shadow word=0; done=0; word_count=0.
  - Outputs read IDLE values: out_enable=0, out_byte=0, out_lh=0, out_funsel=00, in_ready=1 (gated by clear_req, see below).
- States:
  - IDLE, CLEAR, FIRST, SECOND (2-bit encoding).
  - Shadow register holds the accepted word.
- Output decode (combinational from state, shadow and stall only):
  - IDLE: enable=0, byte=0, lh=0, funsel=00.
  - CLEAR: enable=~stall, funsel=00, byte=0, lh=0.
  - FIRST: enable=~stall, funsel=01; LOW_FIRST=1 → byte=shadow[7:0], lh=0; LOW_FIRST=0 → byte=shadow[15:8], lh=1.
  - SECOND: enable=~stall, funsel=01, other half of shadow, complementary lh.
- in_ready = (IDLE & ~clear_req) | (SECOND & ~stall).
- Accept: in_valid & in_ready at a rising edge → shadow<=in_word, next state FIRST. First byte is visible the cycle after acceptance (latency 1).
- Transitions:
  - IDLE: clear_req → CLEAR. Clear has priority over in_valid; in_ready=0 that cycle. Else accept → FIRST. Else stay.
  - CLEAR: ~stall → IDLE. stall → hold.
  - FIRST: ~stall → SECOND. stall → hold; byte/lh held stable.
  - SECOND: ~stall & accept → FIRST with new shadow (back-to-back, one byte per cycle, 2 cycles/word). ~stall & ~accept → IDLE. stall → hold.
- clear_req outside IDLE is ignored (not queued). Requester must hold it until it observes busy.
- done: registered; 1 in the cycle after the SECOND byte's enable edge, else 0. Clear never pulses done.
- word_count: increments with each done, wraps 2^CNT_W-1 → 0.
- Reset mid-word: transfer abandoned, no done, count cleared. Target keeps whatever half was already written.
- in_word changes after acceptance have no effect.

Decomposition:
- Shared package: state encodings (IDLE/CLEAR/FIRST/SECOND), FunSel constants (FS_CLEAR=00, FS_LOAD=01, FS_DEC=10, FS_INC=11), LH constants (LH_LOW=0, LH_HIGH=1).
- No sub-module required. Output decode may be a small combinational function in the same file.

Test Plan:
- Reset with in_valid=1 asserted → all outputs 0, in_ready=1, word_count=0; after release and word 16'hAA05: cycle1 byte=05 lh=0 en=1 fs=01, cycle2 byte=AA lh=1, then done=1, count=1; target register = 16'hAA05.
- Back-to-back 16'h1234, 16'h5678 with in_valid held → bytes 34,12,78,56 on consecutive cycles; in_ready=1 during each SECOND; count=2.
- stall=1 for 3 cycles in FIRST of 16'hBEEF → byte=EF, lh=0, en=0 stable for 3 cycles; resumes EF then BE; single done.
- clear_req and in_valid together in IDLE → in_ready=0; one cycle en=1 fs=00; then word accepted; target = 0 then loaded word.
- LOW_FIRST=0, word 16'hC3A5 → byte C3 lh=1, then A5 lh=0.
- rst_n low during SECOND → outputs immediately 0, no done, count 0; 255 completed words then one more → word_count wraps to 0.

Source files
------------

// File: rtl/word_byte_loader_pkg.sv
// Shared encodings for the byte-wide register-load interface:
// loader states, target FunSel codes and half-select values.
package word_byte_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_FIRST  = 2'd2,
    ST_SECOND = 2'd3
  } state_e;

  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  typedef struct packed {
    logic       enable;
    logic [1:0] funsel;
    logic       lh;
    logic [7:0] data;
  } tgt_cmd_t;

endpackage

// File: rtl/word_byte_loader.sv
// Accepts a 16-bit word over valid/ready and replays it as two byte writes
// into a half-loadable target register; also issues single clear commands.
module word_byte_loader
  import word_byte_loader_pkg::*;
#(
  parameter bit          LOW_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_word,
  input  logic             clear_req,
  input  logic             stall,
  output logic [7:0]       out_byte,
  output logic             out_lh,
  output logic [1:0]       out_funsel,
  output logic             out_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  state_e           r_state;
  state_e           w_next;
  logic [15:0]      r_shadow;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_last;
  tgt_cmd_t         w_cmd;

  // Target pins depend only on state, shadow word and stall.
  function automatic tgt_cmd_t decode(state_e st, logic [15:0] sh, logic stl);
    tgt_cmd_t c;
    logic     hi;
    c  = '0;
    hi = (st == ST_SECOND) ? LOW_FIRST : ~LOW_FIRST;
    case (st)
      ST_CLEAR: begin
        c.enable = ~stl;
        c.funsel = FS_CLEAR;
      end
      ST_FIRST, ST_SECOND: begin
        c.enable = ~stl;
        c.funsel = FS_LOAD;
        c.lh     = hi ? LH_HIGH : LH_LOW;
        c.data   = hi ? sh[15:8] : sh[7:0];
      end
      default: ;
    endcase
    return c;
  endfunction

  assign w_cmd      = decode(r_state, r_shadow, stall);
  assign out_enable = w_cmd.enable;
  assign out_funsel = w_cmd.funsel;
  assign out_lh     = w_cmd.lh;
  assign out_byte   = w_cmd.data;

  assign in_ready   = ((r_state == ST_IDLE) & ~clear_req) |
                      ((r_state == ST_SECOND) & ~stall);
  assign w_accept   = in_valid & in_ready;
  assign w_last     = (r_state == ST_SECOND) & ~stall;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign word_count = r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clear_req)     w_next = ST_CLEAR;
        else if (w_accept) w_next = ST_FIRST;
      end
      ST_CLEAR:  if (!stall) w_next = ST_IDLE;
      ST_FIRST:  if (!stall) w_next = ST_SECOND;
      ST_SECOND: if (!stall) w_next = w_accept ? ST_FIRST : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      if (w_accept) r_shadow <= in_word;
      if (w_last)   r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
